// File: rtl/sprite_blitter_if.sv
// Sprite blitter port bundle: draw-controller request fields, sprite ROM
// read port and the VGA adapter write port, plus FSM state for debug.
// Optional macro SPRITE_BLIT_MIRROR_EN adds the 1-bit mirror request field.
//
// Handshake: start is a one-cycle request that is accepted only while the
// blitter is idle (busy=0 and done=0). The request fields are sampled in
// the accepting cycle. busy then stays high until the cycle in which done
// pulses for exactly one cycle. A start seen while busy or during done is
// dropped, not queued.
interface sprite_blitter_if #(
  parameter int ADDR_W = 13,
  parameter int DIM_W  = 8,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int COL_W  = 3
);
  logic              start;
  logic [X_W-1:0]    base_x;
  logic [Y_W-1:0]    base_y;
  logic [DIM_W-1:0]  spr_w;
  logic [DIM_W-1:0]  spr_h;
  logic [COL_W-1:0]  fg_col;
  logic [COL_W-1:0]  bg_col;
  logic              transparent;
`ifdef SPRITE_BLIT_MIRROR_EN
  logic              mirror;
`endif
  logic              rom_q;
  logic [ADDR_W-1:0] rom_addr;
  logic [X_W-1:0]    vga_x;
  logic [Y_W-1:0]    vga_y;
  logic [COL_W-1:0]  vga_colour;
  logic              vga_plot;
  logic              busy;
  logic              done;
  logic [1:0]        fsm_state;

`ifdef SPRITE_BLIT_MIRROR_EN
  modport slave (
    input  start, base_x, base_y, spr_w, spr_h, fg_col, bg_col, transparent,
           mirror, rom_q,
    output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, fsm_state
  );
  modport master (
    output start, base_x, base_y, spr_w, spr_h, fg_col, bg_col, transparent,
           mirror, rom_q,
    input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, fsm_state
  );
`else
  modport slave (
    input  start, base_x, base_y, spr_w, spr_h, fg_col, bg_col, transparent,
           rom_q,
    output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, fsm_state
  );
  modport master (
    output start, base_x, base_y, spr_w, spr_h, fg_col, bg_col, transparent,
           rom_q,
    input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, fsm_state
  );
`endif
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans a WIDTH x HEIGHT rectangle of a 1-bit sprite ROM in
// row-major order and writes one VGA pixel per visible, non-transparent
// ROM bit. Address-to-plot latency is 2 cycles at 1 pixel per cycle.
// Optional macro SPRITE_BLIT_MIRROR_EN reads each row right-to-left.
module sprite_blitter #(
  parameter int ADDR_W = 13,
  parameter int DIM_W  = 8,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int COL_W  = 3,
  parameter int SCR_W  = 160,
  parameter int SCR_H  = 120
) (
  input logic       clock,
  input logic       resetn,
  sprite_blitter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

  // Sums are one bit wider than the widest operand so wrap-around can never
  // land a pixel back on screen.
  localparam int MAX_W = (X_W > DIM_W) ? ((X_W > Y_W) ? X_W : Y_W)
                                       : ((DIM_W > Y_W) ? DIM_W : Y_W);
  localparam int SUM_W = MAX_W + 1;

  state_t state, state_nxt;

  logic [X_W-1:0]    cap_x;
  logic [Y_W-1:0]    cap_y;
  logic [DIM_W-1:0]  cap_w, cap_h;
  logic [COL_W-1:0]  cap_fg, cap_bg;
  logic              cap_tr;
  logic [DIM_W-1:0]  col, row;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              s1_valid;
  logic [DIM_W-1:0]  s1_col, s1_row;
  logic              drain_cnt;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic [COL_W-1:0]  out_col;
  logic              out_plot;

  logic              accept, zero_dim, last_col, last_row, plot_nxt;
  logic [ADDR_W-1:0] addr_inc;
  logic [SUM_W-1:0]  x_sum, y_sum;

  assign accept   = (state == IDLE) && bus.start;
  assign zero_dim = (bus.spr_w == '0) || (bus.spr_h == '0);
  assign last_col = (col == cap_w - DIM_W'(1));
  assign last_row = (row == cap_h - DIM_W'(1));
  assign addr_inc = rom_addr_r + ADDR_W'(1);

`ifdef SPRITE_BLIT_MIRROR_EN
  logic              cap_mir;
  logic [ADDR_W-1:0] row_base, nxt_base, w_m1;
  assign nxt_base = row_base + ADDR_W'(cap_w);
  assign w_m1     = ADDR_W'(cap_w) - ADDR_W'(1);
`endif

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state: empty sprites skip straight to the done pulse
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = zero_dim ? FIN : RUN;
      RUN:   if (last_col && last_row) state_nxt = DRAIN;
      DRAIN: if (drain_cnt) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and stage-0 scan: one ROM address per RUN cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cap_x <= '0; cap_y <= '0; cap_w <= '0; cap_h <= '0;
      cap_fg <= '0; cap_bg <= '0; cap_tr <= 1'b0;
      col <= '0; row <= '0; rom_addr_r <= '0;
`ifdef SPRITE_BLIT_MIRROR_EN
      cap_mir <= 1'b0; row_base <= '0;
`endif
    end else if (accept) begin
      cap_x <= bus.base_x; cap_y <= bus.base_y;
      cap_w <= bus.spr_w;  cap_h <= bus.spr_h;
      cap_fg <= bus.fg_col; cap_bg <= bus.bg_col; cap_tr <= bus.transparent;
      col <= '0; row <= '0;
`ifdef SPRITE_BLIT_MIRROR_EN
      cap_mir  <= bus.mirror;
      row_base <= '0;
      rom_addr_r <= (bus.mirror && !zero_dim) ? ADDR_W'(bus.spr_w) - ADDR_W'(1) : '0;
`else
      rom_addr_r <= '0;
`endif
    end else if (state == RUN && !(last_col && last_row)) begin
      if (last_col) begin
        col <= '0;
        row <= row + DIM_W'(1);
`ifdef SPRITE_BLIT_MIRROR_EN
        row_base   <= nxt_base;
        rom_addr_r <= cap_mir ? nxt_base + w_m1 : addr_inc;
`else
        rom_addr_r <= addr_inc;
`endif
      end else begin
        col <= col + DIM_W'(1);
`ifdef SPRITE_BLIT_MIRROR_EN
        rom_addr_r <= cap_mir ? rom_addr_r - ADDR_W'(1) : addr_inc;
`else
        rom_addr_r <= addr_inc;
`endif
      end
    end
  end

  // Stage 1: delay the (col,row) tag to line up with rom_q; count drain cycles
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0; s1_col <= '0; s1_row <= '0; drain_cnt <= 1'b0;
    end else begin
      s1_valid  <= (state == RUN);
      s1_col    <= col;
      s1_row    <= row;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  assign x_sum    = SUM_W'(cap_x) + SUM_W'(s1_col);
  assign y_sum    = SUM_W'(cap_y) + SUM_W'(s1_row);
  assign plot_nxt = s1_valid && (x_sum < SUM_W'(SCR_W)) && (y_sum < SUM_W'(SCR_H))
                    && !(cap_tr && !bus.rom_q);

  // Output register: coordinates and colour only move when a pixel is plotted
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_x <= '0; out_y <= '0; out_col <= '0; out_plot <= 1'b0;
    end else begin
      out_plot <= plot_nxt;
      if (plot_nxt) begin
        out_x   <= x_sum[X_W-1:0];
        out_y   <= y_sum[Y_W-1:0];
        out_col <= bus.rom_q ? cap_fg : cap_bg;
      end
    end
  end

  assign bus.rom_addr   = rom_addr_r;
  assign bus.vga_x      = out_x;
  assign bus.vga_y      = out_y;
  assign bus.vga_colour = out_col;
  assign bus.vga_plot   = out_plot;
  assign bus.busy       = (state == RUN) || (state == DRAIN);
  assign bus.done       = (state == FIN);
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: hand-computed plot lists, address
// sweeps and done/busy timing. Build with SPRITE_BLIT_MIRROR_EN to add the
// mirrored-read vectors.
module tb_sprite_blitter;
  logic clock = 1'b0;
  logic resetn = 1'b0;

  // Clock and reset
  always #5 clock = ~clock;

  sprite_blitter_if bus ();
  sprite_blitter dut (.clock(clock), .resetn(resetn), .bus(bus));

  // Sprite ROM model: registered address, unregistered output
  logic        rom_mem [0:8191];
  logic [12:0] rom_ra;
  always_ff @(posedge clock) rom_ra <= bus.rom_addr;
  assign bus.rom_q = rom_mem[rom_ra];

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [17:0] exp_q [$];
  logic [17:0] obs_q [$];
  int          plot_cyc [$];
  logic [12:0] addr_q [$];
  int          addr_cyc [$];
  int          done_cnt, done_cyc, busy_gap, busy_after, hold_bad;
`ifdef SPRITE_BLIT_MIRROR_EN
  logic        mir = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] pk(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    return {x, y, c};
  endfunction

  task automatic load_pattern();
    logic [7:0] pat;
    pat = 8'b1010_0101; // addr 0..7 = 1,0,1,0,0,1,0,1 (bit 0 first)
    for (int i = 0; i < 8192; i++) rom_mem[i] = 1'b0;
    for (int i = 0; i < 8; i++) rom_mem[i] = pat[i];
  endtask

  task automatic load_ones();
    for (int i = 0; i < 8192; i++) rom_mem[i] = 1'b1;
  endtask

  task automatic check_plots(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_pixel"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  // Driver: issue one start and record everything until done (+3 cycles)
  // or the cycle budget runs out. Cycle 1 is the first cycle after the
  // accepting edge. A second start can be injected at cycle restart_at.
  task automatic run_blit(input logic [7:0] bx, input logic [6:0] by,
                          input logic [7:0] w, input logic [7:0] h,
                          input logic [2:0] fg, input logic [2:0] bg,
                          input logic tr, input int restart_at);
    int cyc, stop_at;
    logic have;
    logic [17:0] last;
    obs_q.delete(); plot_cyc.delete(); addr_q.delete(); addr_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_gap = 0; busy_after = 0; hold_bad = 0;
    have = 1'b0; last = '0;
    @(negedge clock);
    bus.base_x = bx; bus.base_y = by; bus.spr_w = w; bus.spr_h = h;
    bus.fg_col = fg; bus.bg_col = bg; bus.transparent = tr;
`ifdef SPRITE_BLIT_MIRROR_EN
    bus.mirror = mir;
`endif
    bus.start = 1'b1;
    cyc = 0;
    stop_at = 100;
    while (cyc < stop_at) begin
      @(negedge clock);
      cyc++;
      bus.start = (cyc == restart_at);
      if (cyc == restart_at) bus.base_x = 8'd50;
      if (bus.fsm_state == 2'd1) begin
        addr_q.push_back(bus.rom_addr);
        addr_cyc.push_back(cyc);
      end
      if (bus.vga_plot) begin
        last = pk(bus.vga_x, bus.vga_y, bus.vga_colour);
        obs_q.push_back(last);
        plot_cyc.push_back(cyc);
        have = 1'b1;
      end else if (have && pk(bus.vga_x, bus.vga_y, bus.vga_colour) != last) begin
        hold_bad++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        if (stop_at == 100) stop_at = cyc + 3;
      end else if (done_cnt == 0 && !bus.busy) begin
        busy_gap++;
      end else if (done_cnt > 0 && bus.busy) begin
        busy_after++;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic push_basic();
    exp_q.push_back(pk(8'd10, 7'd20, 3'd7)); exp_q.push_back(pk(8'd11, 7'd20, 3'd0));
    exp_q.push_back(pk(8'd12, 7'd20, 3'd7)); exp_q.push_back(pk(8'd13, 7'd20, 3'd0));
    exp_q.push_back(pk(8'd10, 7'd21, 3'd0)); exp_q.push_back(pk(8'd11, 7'd21, 3'd7));
    exp_q.push_back(pk(8'd12, 7'd21, 3'd0)); exp_q.push_back(pk(8'd13, 7'd21, 3'd7));
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.base_x = '0; bus.base_y = '0; bus.spr_w = '0; bus.spr_h = '0;
    bus.fg_col = '0; bus.bg_col = '0; bus.transparent = 1'b0;
`ifdef SPRITE_BLIT_MIRROR_EN
    bus.mirror = 1'b0;
`endif
    load_pattern();

    // Reset state
    #12;
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_vga_x", bus.vga_x, 0);
    check("rst_vga_y", bus.vga_y, 0);
    check("rst_colour", bus.vga_colour, 0);
    check("rst_plot", bus.vga_plot, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", bus.fsm_state, 0);
    @(negedge clock);
    resetn = 1'b1;

    // 4x2 opaque blit
    run_blit(8'd10, 7'd20, 8'd4, 8'd2, 3'd7, 3'd0, 1'b0, -1);
    check("t1_addr_count", addr_q.size(), 8);
    for (int i = 0; i < 8 && i < addr_q.size(); i++) check("t1_addr", addr_q[i], i);
    check("t1_first_plot_cyc", plot_cyc.size() > 0 ? plot_cyc[0] : -1, 3);
    check("t1_latency", (plot_cyc.size() > 0 && addr_cyc.size() > 0) ? plot_cyc[0] - addr_cyc[0] : -1, 2);
    for (int i = 1; i < plot_cyc.size(); i++) check("t1_consecutive", plot_cyc[i] - plot_cyc[i-1], 1);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_cyc", done_cyc, 11);
    check("t1_busy_gap", busy_gap, 0);
    push_basic();
    check_plots("t1");

    // Same sprite, transparent background
    run_blit(8'd10, 7'd20, 8'd4, 8'd2, 3'd7, 3'd0, 1'b1, -1);
    exp_q.push_back(pk(8'd10, 7'd20, 3'd7)); exp_q.push_back(pk(8'd12, 7'd20, 3'd7));
    exp_q.push_back(pk(8'd11, 7'd21, 3'd7)); exp_q.push_back(pk(8'd13, 7'd21, 3'd7));
    check("t2_hold", hold_bad, 0);
    check("t2_done_cnt", done_cnt, 1);
    check_plots("t2");

    // Clipping at the bottom-right corner
    load_ones();
    run_blit(8'd158, 7'd118, 8'd4, 8'd4, 3'd5, 3'd2, 1'b0, -1);
    check("t3_addr_count", addr_q.size(), 16);
    for (int i = 0; i < 16 && i < addr_q.size(); i++) check("t3_addr", addr_q[i], i);
    check("t3_done_cnt", done_cnt, 1);
    exp_q.push_back(pk(8'd158, 7'd118, 3'd5)); exp_q.push_back(pk(8'd159, 7'd118, 3'd5));
    exp_q.push_back(pk(8'd158, 7'd119, 3'd5)); exp_q.push_back(pk(8'd159, 7'd119, 3'd5));
    check_plots("t3");

    // Zero-width sprite
    run_blit(8'd10, 7'd20, 8'd0, 8'd2, 3'd7, 3'd0, 1'b0, -1);
    check("t4_no_sweep", addr_q.size(), 0);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_done_lat", (done_cyc >= 1 && done_cyc <= 2), 1);
    check_plots("t4");

    // Second start while busy is dropped (and its new base_x ignored)
    load_pattern();
    run_blit(8'd10, 7'd20, 8'd4, 8'd2, 3'd7, 3'd0, 1'b0, 4);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_busy_after", busy_after, 0);
    push_basic();
    check_plots("t5");

    // Start during the done cycle is dropped
    run_blit(8'd10, 7'd20, 8'd4, 8'd2, 3'd7, 3'd0, 1'b0, 11);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_busy_after", busy_after, 0);
    push_basic();
    check_plots("t6");

    // Reset mid-blit at pixel 3 of a 20x20 sprite
    load_ones();
    @(negedge clock);
    bus.base_x = 8'd0; bus.base_y = 7'd0; bus.spr_w = 8'd20; bus.spr_h = 8'd20;
    bus.fg_col = 3'd6; bus.bg_col = 3'd1; bus.transparent = 1'b0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n < 3; i++) begin
      if (bus.vga_plot) n++;
      if (n < 3) @(negedge clock);
    end
    check("t7_reach_px3", n, 3);
    #1 resetn = 1'b0;
    #1;
    check("t7_plot_async", bus.vga_plot, 0);
    check("t7_busy", bus.busy, 0);
    check("t7_rom_addr", bus.rom_addr, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.done || bus.vga_plot) n++;
    end
    check("t7_no_done", n, 0);
    resetn = 1'b1;
    load_pattern();
    run_blit(8'd10, 7'd20, 8'd4, 8'd2, 3'd7, 3'd0, 1'b0, -1);
    check("t7_restart_addr0", addr_q.size() > 0 ? addr_q[0] : 13'h1fff, 0);
    check("t7_done_cnt", done_cnt, 1);
    push_basic();
    check_plots("t7");

`ifdef SPRITE_BLIT_MIRROR_EN
    // Mirrored read: addresses 3,2,1,0,7,6,5,4 while x runs 10..13
    mir = 1'b1;
    run_blit(8'd10, 7'd20, 8'd4, 8'd2, 3'd7, 3'd0, 1'b0, -1);
    mir = 1'b0;
    begin
      logic [12:0] mexp [8];
      mexp = '{13'd3, 13'd2, 13'd1, 13'd0, 13'd7, 13'd6, 13'd5, 13'd4};
      check("t8_addr_count", addr_q.size(), 8);
      for (int i = 0; i < 8 && i < addr_q.size(); i++) check("t8_addr", addr_q[i], mexp[i]);
    end
    check("t8_first_plot_cyc", plot_cyc.size() > 0 ? plot_cyc[0] : -1, 3);
    check("t8_done_cnt", done_cnt, 1);
    exp_q.push_back(pk(8'd10, 7'd20, 3'd0)); exp_q.push_back(pk(8'd11, 7'd20, 3'd7));
    exp_q.push_back(pk(8'd12, 7'd20, 3'd0)); exp_q.push_back(pk(8'd13, 7'd20, 3'd7));
    exp_q.push_back(pk(8'd10, 7'd21, 3'd7)); exp_q.push_back(pk(8'd11, 7'd21, 3'd0));
    exp_q.push_back(pk(8'd12, 7'd21, 3'd7)); exp_q.push_back(pk(8'd13, 7'd21, 3'd0));
    check_plots("t8");
`endif

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
